// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: pipeline hazard controller (load-use stall, forwarding, branch flush, dmem freeze, halt drain)
module hazard_ctrl_param #(
  parameter int REG_W        = 3,
  parameter int LOAD_BUBBLES = 1,
  parameter int DRAIN_CYC    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       pc_src,
  input  logic             halt_req,
  input  logic             dmem_busy,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_rs_vld,
  input  logic             if_id_rt_vld,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rs,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             ex_mem_reg_write,
  input  logic [REG_W-1:0] ex_mem_rd,
  input  logic             mem_wb_reg_write,
  input  logic [REG_W-1:0] mem_wb_rd,
  output logic             pc_hold,
  output logic             fd_hold,
  output logic             de_hold,
  output logic             em_hold,
  output logic             mw_hold,
  output logic             fd_nop,
  output logic             de_nop,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted
);
  typedef enum logic [1:0] {RUN, LSTALL, DRAIN, HALTED} state_t;
  state_t state, state_nx;
  logic [2:0] bubble_cnt, bubble_cnt_nx;
  logic [3:0] drain_cnt, drain_cnt_nx;
  logic taken, luh, flow, stall, fetch_stop, flush;
  assign taken = pc_src == 3'b010 || pc_src == 3'b011;
  assign luh = id_ex_mem_read && ((if_id_rs_vld && id_ex_rt == if_id_rs) || (if_id_rt_vld && id_ex_rt == if_id_rt));
  assign fwd_a = (ex_mem_reg_write && ex_mem_rd == id_ex_rs) ? 2'b10 : (mem_wb_reg_write && mem_wb_rd == id_ex_rs) ? 2'b01 : 2'b00;
  assign fwd_b = (ex_mem_reg_write && ex_mem_rd == id_ex_rt) ? 2'b10 : (mem_wb_reg_write && mem_wb_rd == id_ex_rt) ? 2'b01 : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      bubble_cnt <= '0;
      drain_cnt  <= '0;
    end else begin
      state      <= state_nx;
      bubble_cnt <= bubble_cnt_nx;
      drain_cnt  <= drain_cnt_nx;
    end
  end
  always_comb begin
    state_nx      = state;
    bubble_cnt_nx = bubble_cnt;
    drain_cnt_nx  = drain_cnt;
    if (!dmem_busy) begin
      case (state)
        RUN: begin
          if (!taken && halt_req) begin
            state_nx     = DRAIN;
            drain_cnt_nx = 4'(DRAIN_CYC - 1);
          end else if (!taken && luh && LOAD_BUBBLES > 1) begin
            state_nx      = LSTALL;
            bubble_cnt_nx = 3'(LOAD_BUBBLES - 1);
          end
        end
        LSTALL: begin
          state_nx      = (taken || bubble_cnt == 3'd1) ? RUN : LSTALL;
          bubble_cnt_nx = taken ? 3'd0 : bubble_cnt - 3'd1;
        end
        DRAIN: begin
          state_nx     = (drain_cnt == 4'd0) ? HALTED : DRAIN;
          drain_cnt_nx = (drain_cnt == 4'd0) ? drain_cnt : drain_cnt - 4'd1;
        end
        default: state_nx = HALTED;
      endcase
    end
  end
  // flow: not frozen by memory; a taken branch in RUN/LSTALL overrides halt and stall
  always_comb begin
    flow       = !dmem_busy;
    flush      = flow && taken && (state == RUN || state == LSTALL);
    stall      = flow && !taken && ((state == LSTALL) || (state == RUN && !halt_req && luh));
    fetch_stop = flow && (state == DRAIN || state == HALTED || (state == RUN && !taken && halt_req));
    pc_hold    = dmem_busy || stall || fetch_stop;
    fd_hold    = dmem_busy || stall;
    de_hold    = dmem_busy;
    em_hold    = dmem_busy;
    mw_hold    = dmem_busy;
    fd_nop     = flush || fetch_stop;
    de_nop     = flush || stall;
    halted     = state == HALTED;
  end
endmodule
